// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the Nexys Starship game blocks:
// room state encoding, combo type and the 8-bit LFSR step function.
package nexys_starship_pkg;

  typedef enum logic [2:0] {
    ROOM_INIT    = 3'b001,
    ROOM_WORKING = 3'b010,
    ROOM_REPAIR  = 3'b100
  } room_state_e;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1

  localparam int COMBO_W = 4;
  typedef logic [COMBO_W-1:0] combo_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nexys_starship_room_ctrl_if.sv
// Game-side bundle for one room controller: play/repair controls in,
// state flags, repair combo and result pulses out.
interface nexys_starship_room_ctrl_if;

  logic                       play_flag;
  logic                       game_over;
  logic                       room_sel;
  logic                       submit;
  nexys_starship_pkg::combo_t hex_combo;
  logic                       force_break;

  logic                       q_Init;
  logic                       q_Working;
  logic                       q_Repair;
  nexys_starship_pkg::combo_t repair_combo;
  logic                       repaired;
  logic                       repair_fail;
  logic                       room_lost;

  modport master (
    output play_flag, game_over, room_sel, submit, hex_combo, force_break,
    input  q_Init, q_Working, q_Repair, repair_combo, repaired, repair_fail, room_lost
  );

  modport slave (
    input  play_flag, game_over, room_sel, submit, hex_combo, force_break,
    output q_Init, q_Working, q_Repair, repair_combo, repaired, repair_fail, room_lost
  );

endinterface

// File: rtl/nexys_starship_lfsr8.sv
// 8-bit Fibonacci LFSR with enable; a zero seed is coerced to 1 so the
// register can never lock up in the all-zero state.
module nexys_starship_lfsr8
  import nexys_starship_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  output logic [7:0] state
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = en ? lfsr_next(lfsr_q) : lfsr_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/nexys_starship_room_ctrl.sv
// Per-room damage/repair controller: randomly breaks the room during play,
// accepts the player's repair combo and flags room_lost on repair timeout.
module nexys_starship_room_ctrl
  import nexys_starship_pkg::*;
#(
  parameter int unsigned BREAK_INTERVAL = 100_000_000,
  parameter int unsigned REPAIR_TIMEOUT = 1_000_000_000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input logic                       Clk,
  input logic                       Reset,
  nexys_starship_room_ctrl_if.slave bus
);

  localparam int TICK_W = $clog2(BREAK_INTERVAL);
  localparam int TMR_W  = $clog2(REPAIR_TIMEOUT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BREAK_INTERVAL - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(REPAIR_TIMEOUT);

  room_state_e        state_q,  state_d;
  logic [TICK_W-1:0]  tick_q,   tick_d;
  logic [TMR_W-1:0]   timer_q,  timer_d;
  combo_t             combo_q,  combo_d;
  logic               repaired_q,    repaired_d;
  logic               repair_fail_q, repair_fail_d;
  logic               room_lost_q,   room_lost_d;

  logic [7:0] lfsr_state;
  logic       lfsr_en;
  logic       lfsr_low_zero;
  combo_t     lfsr_combo;
  logic       tick_wrap;
  logic       attempt;
  logic       match;

  // The LFSR also freezes on a game_over cycle so Gameover never reseeds it.
  assign lfsr_en = (state_q != ROOM_INIT) && !bus.game_over;

  nexys_starship_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (lfsr_en),
    .state (lfsr_state)
  );

  assign lfsr_low_zero = (lfsr_state & 8'h07) == 8'h00;
  assign lfsr_combo    = combo_t'(lfsr_state >> 4);
  assign tick_wrap     = (tick_q == TICK_LAST);
  assign attempt       = bus.submit && bus.room_sel;
  assign match         = attempt && (bus.hex_combo == combo_q);

  always_comb begin
    // NOTE: every _d gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d       = state_q;
    tick_d        = tick_q;
    timer_d       = timer_q;
    combo_d       = combo_q;
    room_lost_d   = room_lost_q;
    repaired_d    = 1'b0;
    repair_fail_d = 1'b0;

    if (bus.game_over) begin
      state_d     = ROOM_INIT;
      tick_d      = '0;
      timer_d     = '0;
      combo_d     = '0;
      room_lost_d = 1'b0;
    end else begin
      unique case (state_q)
        ROOM_INIT: begin
          if (bus.play_flag) state_d = ROOM_WORKING;
        end

        ROOM_WORKING: begin
          tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
          if ((tick_wrap && lfsr_low_zero) || bus.force_break) begin
            state_d = ROOM_REPAIR;
            combo_d = lfsr_combo;
            timer_d = TMR_LOAD;
          end
        end

        ROOM_REPAIR: begin
          if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
          if (match) begin
            // A match on the expiry cycle wins, so room_lost is not touched here.
            state_d    = ROOM_WORKING;
            repaired_d = 1'b1;
            combo_d    = '0;
            tick_d     = '0;
            timer_d    = '0;
          end else begin
            if (attempt)         repair_fail_d = 1'b1;
            if (timer_q == '0)   room_lost_d   = 1'b1;
          end
        end

        default: state_d = ROOM_INIT;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ROOM_INIT;
      tick_q        <= '0;
      timer_q       <= '0;
      combo_q       <= '0;
      repaired_q    <= 1'b0;
      repair_fail_q <= 1'b0;
      room_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      timer_q       <= timer_d;
      combo_q       <= combo_d;
      repaired_q    <= repaired_d;
      repair_fail_q <= repair_fail_d;
      room_lost_q   <= room_lost_d;
    end
  end

  assign bus.q_Init       = (state_q == ROOM_INIT);
  assign bus.q_Working    = (state_q == ROOM_WORKING);
  assign bus.q_Repair     = (state_q == ROOM_REPAIR);
  assign bus.repair_combo = combo_q;
  assign bus.repaired     = repaired_q;
  assign bus.repair_fail  = repair_fail_q;
  assign bus.room_lost    = room_lost_q;

endmodule
